// File: rtl/sync_debounce.sv
// Synchroniser plus 4-state debounce FSM producing a clean level and rise/fall strobes.
// Optional glitch counter: define SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_cnt
);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_CHK_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   q_d, rise_d, fall_d;

    // Synchroniser: the only consumer of the raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        q_d     = q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state)
            S_LOW: begin
                if (s) begin
                    state_d = S_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            S_CHK_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_HIGH;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            S_CHK_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_LOW;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                q_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            q     <= q_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic abort;

    // An abort is a check state falling back to the level it started from.
    assign abort = ((state == S_CHK_HIGH) && !s) || ((state == S_CHK_LOW) && s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 8'h00;
        end else if (abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`else
    assign glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce (SYNC_STAGES=2, STABLE_CYCLES=4); vector table plus corner sequences.
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       q, rise, fall;
    logic [7:0] glitch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    sync_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .q          (q),
        .rise       (rise),
        .fall       (fall),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       din;
        logic       q;
        logic       rise;
        logic       fall;
        logic [7:0] gc;   // value with the glitch counter built
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic d, logic eq, logic er, logic ef, logic [7:0] eg);
        vec_t v;
        v.din = d; v.q = eq; v.rise = er; v.fall = ef; v.gc = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic eq, input logic er, input logic ef);
        chk({name, ".q"}, {7'd0, q}, {7'd0, eq});
        chk({name, ".rise"}, {7'd0, rise}, {7'd0, er});
        chk({name, ".fall"}, {7'd0, fall}, {7'd0, ef});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (2) edge_step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Edge k: din applied before edge k, outputs expected after edge k.
        tbl[0]  = mk(1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 0, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 0);
        tbl[13] = mk(1, 1, 0, 0, 1);
        tbl[14] = mk(1, 1, 0, 0, 1);
        tbl[15] = mk(0, 1, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 0, 1);
        tbl[17] = mk(0, 1, 0, 0, 1);
        tbl[18] = mk(0, 1, 0, 0, 1);
        tbl[19] = mk(1, 1, 0, 0, 1);
        tbl[20] = mk(1, 0, 0, 1, 1);
        tbl[21] = mk(1, 0, 0, 0, 1);
        tbl[22] = mk(1, 0, 0, 0, 1);
        tbl[23] = mk(1, 0, 0, 0, 1);
        tbl[24] = mk(1, 1, 1, 0, 1);
        tbl[25] = mk(1, 1, 0, 0, 1);

        // Reset state, checked while rst is still asserted.
        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.glitch_cnt", glitch_cnt, 8'h00);
        #10;
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            din = tbl[i].din;
            edge_step();
            chk_outs($sformatf("vec%0d", i), tbl[i].q, tbl[i].rise, tbl[i].fall);
            chk($sformatf("vec%0d.glitch_cnt", i), glitch_cnt, GC_EN ? tbl[i].gc : 8'h00);
        end

        // Fast toggling never qualifies; the glitch counter saturates.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            din = ~din;
            edge_step();
            chk_outs($sformatf("toggle%0d", i), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 550; i++) begin
            din = ~din;
            edge_step();
        end
        chk_outs("toggle600", 1'b0, 1'b0, 1'b0);
        chk("toggle600.glitch_cnt", glitch_cnt, GC_EN ? 8'hFF : 8'h00);

        // Asynchronous reset clears q=1 without a clock edge.
        do_reset();
        din = 1'b1;
        repeat (8) edge_step();
        chk("pre_async.q", {7'd0, q}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async_clr", 1'b0, 1'b0, 1'b0);
        chk("async_clr.glitch_cnt", glitch_cnt, 8'h00);
        edge_step();
        #2;
        rst = 1'b0;

        // Reach S_CHK_HIGH with cnt=2, then pulse reset between edges.
        repeat (4) edge_step();
        chk_outs("chk_high_cnt2", 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("mid_rst", 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            edge_step();
            chk_outs($sformatf("post_rst_e%0d", k), 1'b0, 1'b0, 1'b0);
        end
        edge_step();
        chk_outs("post_rst_e5", 1'b1, 1'b1, 1'b0);
        edge_step();
        chk_outs("post_rst_e6", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
